// File: rtl/systolic_feeder_2x2.sv
// Operand sequencer for the 2x2 systolic array: captures A and B on start, then
// issues four skewed wavefront steps spaced by a cycle gap or by array_done.
module systolic_feeder_2x2 #(
    parameter int DW        = 32,
    parameter int GAP       = 20,
    parameter int WAIT_DONE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] a11,
    input  logic [DW-1:0] a12,
    input  logic [DW-1:0] a21,
    input  logic [DW-1:0] a22,
    input  logic [DW-1:0] b11,
    input  logic [DW-1:0] b12,
    input  logic [DW-1:0] b21,
    input  logic [DW-1:0] b22,
    input  logic          array_done,
    output logic          busy,
    output logic          load_in,
    output logic [DW-1:0] row_in_row0,
    output logic [DW-1:0] row_in_row1,
    output logic [DW-1:0] col_in_col0,
    output logic [DW-1:0] col_in_col1,
    output logic          feed_done
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

    localparam logic [7:0] GAP_LD = 8'(GAP - 2);

    state_t        state_q, state_d;
    logic [1:0]    step_q, step_d, nstep;
    logic [7:0]    cnt_q, cnt_d;
    logic          cap, upd, adv;
    logic [DW-1:0] a11_q, a12_q, a21_q, a22_q, b11_q, b12_q, b21_q, b22_q;
    logic [DW-1:0] row0_q, row1_q, col0_q, col1_q;
    logic [DW-1:0] row0_d, row1_d, col0_d, col1_d;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        nstep   = step_q;
        cap     = 1'b0;
        upd     = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                step_d = 2'd0;
                if (start) begin
                    state_d = LOAD;
                    cap     = 1'b1;
                    upd     = 1'b1;
                    nstep   = 2'd0;
                end
            end
            LOAD: begin
                state_d = WAIT;
                cnt_d   = GAP_LD;
            end
            WAIT: begin
                if (WAIT_DONE != 0) begin
                    adv = array_done;
                end else begin
                    adv = (cnt_q == 8'd0);
                    if (!adv) cnt_d = cnt_q - 8'd1;
                end
                if (adv) begin
                    if (step_q != 2'd3) begin
                        nstep   = step_q + 2'd1;
                        step_d  = step_q + 2'd1;
                        upd     = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                step_d  = 2'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Step 0 is only ever loaded from IDLE, on the same edge that captures the
    // operands, so it must take a12/b21 straight from the inputs.
    always_comb begin
        row0_d = row0_q;
        row1_d = row1_q;
        col0_d = col0_q;
        col1_d = col1_q;
        case (nstep)
            2'd0: begin
                row0_d = (state_q == IDLE) ? a12 : a12_q;
                row1_d = '0;
                col0_d = (state_q == IDLE) ? b21 : b21_q;
                col1_d = '0;
            end
            2'd1: begin
                row0_d = a11_q;
                row1_d = a22_q;
                col0_d = b11_q;
                col1_d = b22_q;
            end
            2'd2: begin
                row0_d = '0;
                row1_d = a21_q;
                col0_d = '0;
                col1_d = b12_q;
            end
            default: begin
                row0_d = '0;
                row1_d = '0;
                col0_d = '0;
                col1_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            cnt_q   <= 8'd0;
            a11_q   <= '0;
            a12_q   <= '0;
            a21_q   <= '0;
            a22_q   <= '0;
            b11_q   <= '0;
            b12_q   <= '0;
            b21_q   <= '0;
            b22_q   <= '0;
            row0_q  <= '0;
            row1_q  <= '0;
            col0_q  <= '0;
            col1_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            if (cap) begin
                a11_q <= a11;
                a12_q <= a12;
                a21_q <= a21;
                a22_q <= a22;
                b11_q <= b11;
                b12_q <= b12;
                b21_q <= b21;
                b22_q <= b22;
            end
            if (upd) begin
                row0_q <= row0_d;
                row1_q <= row1_d;
                col0_q <= col0_d;
                col1_q <= col1_d;
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign load_in     = (state_q == LOAD);
    assign feed_done   = (state_q == DONE);
    assign row_in_row0 = row0_q;
    assign row_in_row1 = row1_q;
    assign col_in_col0 = col0_q;
    assign col_in_col1 = col1_q;

endmodule
